ysyx_22040386_hazard_ctrl: RTL and testbench
============================================

// Module: ysyx_22040386_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage core: drives stall/flush/redirect for PC, IF/ID, ID/EX, EX/MEM.
//  Detects load-use hazards, applies jump redirects from EX, and absorbs multi-cycle IMEM/DMEM waits.
//  Discards a stale in-flight fetch after a redirect. Keeps saturating stall/redirect performance counters.
// PARAMETERS
//  RA_W    5   register address width
//  CNT_W  32   performance counter width
// PORTS
//  i_HC_clk            in   1      clock, posedge
//  i_HC_rst_n          in   1      reset, asynchronous, active-low
//  i_HC_id_rs1         in   RA_W   rs1 address of instruction in IF/ID
//  i_HC_id_rs2         in   RA_W   rs2 address of instruction in IF/ID
//  i_HC_id_use_rs1     in   1      ID instruction reads rs1
//  i_HC_id_use_rs2     in   1      ID instruction reads rs2
//  i_HC_ex_rd          in   RA_W   rd of instruction in ID/EX
//  i_HC_ex_mem_read    in   1      ID/EX instruction is a load
//  i_HC_ex_jump        in   1      EX resolved taken branch/jump
//  i_HC_imem_busy      in   1      instruction fetch not complete this cycle
//  i_HC_dmem_busy      in   1      data access in MEM not complete this cycle
//  o_HC_pc_stall       out  1      hold PC
//  o_HC_pc_redirect    out  1      PC loads EX jump target
//  o_HC_if_id_stall    out  1      hold IF/ID (load-use flag)
//  o_HC_if_id_flush    out  1      IF/ID loads NOP 32'h13 (jump flag)
//  o_HC_id_ex_stall    out  1      hold ID/EX
//  o_HC_id_ex_flush    out  1      ID/EX loads bubble
//  o_HC_ex_mem_stall   out  1      hold EX/MEM
//  o_HC_state          out  2      current FSM state (debug)
//  o_HC_stall_cnt      out  CNT_W  cycles with o_HC_pc_stall=1, saturating
//  o_HC_redir_cnt      out  CNT_W  redirect events, saturating
// BEHAVIOUR
//  - Control outputs combinational from state + inputs (same-cycle effect on pipeline regs); state/counters registered.
//  - rst_n low: state=RUN, counters=0, all control outputs 0 immediately (async); mid-wait reset aborts wait.
//  - lu = ex_mem_read & ex_rd!=0 & ((use_rs1 & ex_rd==rs1) | (use_rs2 & ex_rd==rs2)).
//  - States: RUN=0, MEM_WAIT=1, DISCARD=2.
//  - RUN, first match wins:
//    1 dmem_busy: pc/if_id/id_ex/ex_mem stall=1, no flush/redirect; next MEM_WAIT.
//    2 ex_jump: pc_redirect=1, if_id_flush=1, id_ex_flush=1; imem_busy ? next DISCARD : stay RUN.
//    3 lu: pc_stall=1, if_id_stall=1, id_ex_flush=1 (exactly one bubble; next cycle ID/EX is bubble so lu=0).
//    4 imem_busy: pc_stall=1, if_id_flush=1 (fetch bubble).
//    5 else all 0.
//  - MEM_WAIT: pc/if_id/id_ex/ex_mem stall=1 while dmem_busy; jump/lu ignored (EX frozen).
//    dmem_busy=0: outputs evaluated as RUN rules 2-5 this cycle, next RUN.
//  - DISCARD: pc_stall=1 (PC holds target), if_id_flush=1 every cycle; stale fetch result dropped.
//    dmem_busy also set: id_ex_stall=ex_mem_stall=1 additionally. imem_busy=0: still flush this cycle, next RUN.
//    ex_jump in DISCARD ignored (EX holds bubble after redirect).
//  - Counters: stall_cnt +1 per cycle pc_stall=1; redir_cnt +1 per cycle pc_redirect=1; both hold at all-ones.
//  - Never assert stall and flush on the same register together.
// TESTING
//  - lu: ex_mem_read=1, ex_rd=5, rs1=5, use_rs1=1 -> one cycle pc_stall=if_id_stall=id_ex_flush=1, then all 0.
//  - ex_rd=0 load matching rs1=0 -> no stall; use_rs2=0 with rs2 match -> no stall.
//  - ex_jump=1, imem_busy=0 -> redirect+if_id_flush+id_ex_flush one cycle, state stays 0, redir_cnt=1.
//  - ex_jump=1 with imem_busy held 3 cycles -> state 2, if_id_flush=1 for 3 cycles, then state 0.
//  - dmem_busy 4 cycles with lu and jump present -> all stalls 4 cycles, stall_cnt=4, then jump applied.
//  - rst_n low mid MEM_WAIT -> outputs 0 same cycle, state 0, counters 0; CNT_W=4 counter saturates at 15.

Source files
------------

// File: rtl/ysyx_22040386_hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: turns load-use hazards, EX jumps and
// IMEM/DMEM wait states into stall/flush/redirect strobes for the pipeline
// registers, and keeps saturating stall/redirect counters.
`timescale 1ns/1ps
module ysyx_22040386_hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             i_HC_clk,
  input  logic             i_HC_rst_n,
  input  logic [RA_W-1:0]  i_HC_id_rs1,
  input  logic [RA_W-1:0]  i_HC_id_rs2,
  input  logic             i_HC_id_use_rs1,
  input  logic             i_HC_id_use_rs2,
  input  logic [RA_W-1:0]  i_HC_ex_rd,
  input  logic             i_HC_ex_mem_read,
  input  logic             i_HC_ex_jump,
  input  logic             i_HC_imem_busy,
  input  logic             i_HC_dmem_busy,
  output logic             o_HC_pc_stall,
  output logic             o_HC_pc_redirect,
  output logic             o_HC_if_id_stall,
  output logic             o_HC_if_id_flush,
  output logic             o_HC_id_ex_stall,
  output logic             o_HC_id_ex_flush,
  output logic             o_HC_ex_mem_stall,
  output logic [1:0]       o_HC_state,
  output logic [CNT_W-1:0] o_HC_stall_cnt,
  output logic [CNT_W-1:0] o_HC_redir_cnt
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_DISCARD  = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_stall;
    logic pc_redirect;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
  } ctl_t;

  state_e state_q, state_d;
  ctl_t   run_ctl, ctl;
  logic   lu;

  // Load in EX whose rd feeds a source the ID instruction actually reads (x0 never hazards).
  assign lu = i_HC_ex_mem_read && (i_HC_ex_rd != '0) &&
              ((i_HC_id_use_rs1 && (i_HC_ex_rd == i_HC_id_rs1)) ||
               (i_HC_id_use_rs2 && (i_HC_ex_rd == i_HC_id_rs2)));

  // Priority jump > load-use > fetch bubble; shared by RUN and the MEM_WAIT release cycle.
  always_comb begin
    run_ctl = '0;
    if (i_HC_ex_jump) begin
      run_ctl.pc_redirect = 1'b1;
      run_ctl.if_id_flush = 1'b1;
      run_ctl.id_ex_flush = 1'b1;
    end else if (lu) begin
      run_ctl.pc_stall    = 1'b1;
      run_ctl.if_id_stall = 1'b1;
      run_ctl.id_ex_flush = 1'b1;
    end else if (i_HC_imem_busy) begin
      run_ctl.pc_stall    = 1'b1;
      run_ctl.if_id_flush = 1'b1;
    end
  end

  // Per-state control strobes and next state; reset forces all strobes low at once.
  always_comb begin
    ctl     = '0;
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (i_HC_dmem_busy) begin
          ctl.pc_stall     = 1'b1;
          ctl.if_id_stall  = 1'b1;
          ctl.id_ex_stall  = 1'b1;
          ctl.ex_mem_stall = 1'b1;
          state_d          = S_MEM_WAIT;
        end else begin
          ctl = run_ctl;
          // A redirect while a fetch is still outstanding must drop that stale fetch.
          if (i_HC_ex_jump && i_HC_imem_busy) state_d = S_DISCARD;
        end
      end
      S_MEM_WAIT: begin
        // Whole pipe frozen; EX contents are not acted on until the access completes.
        if (i_HC_dmem_busy) begin
          ctl.pc_stall     = 1'b1;
          ctl.if_id_stall  = 1'b1;
          ctl.id_ex_stall  = 1'b1;
          ctl.ex_mem_stall = 1'b1;
        end else begin
          ctl     = run_ctl;
          state_d = S_RUN;
        end
      end
      S_DISCARD: begin
        // PC already holds the target; IF/ID keeps loading NOP until the stale fetch retires.
        ctl.pc_stall    = 1'b1;
        ctl.if_id_flush = 1'b1;
        if (i_HC_dmem_busy) begin
          ctl.id_ex_stall  = 1'b1;
          ctl.ex_mem_stall = 1'b1;
        end
        if (!i_HC_imem_busy) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
    if (!i_HC_rst_n) ctl = '0;
  end

  // State register.
  always_ff @(posedge i_HC_clk or negedge i_HC_rst_n) begin
    if (!i_HC_rst_n) state_q <= S_RUN;
    else             state_q <= state_d;
  end

  // Saturating performance counters.
  always_ff @(posedge i_HC_clk or negedge i_HC_rst_n) begin
    if (!i_HC_rst_n) begin
      o_HC_stall_cnt <= '0;
      o_HC_redir_cnt <= '0;
    end else begin
      if (ctl.pc_stall && (o_HC_stall_cnt != '1))
        o_HC_stall_cnt <= o_HC_stall_cnt + CNT_W'(1);
      if (ctl.pc_redirect && (o_HC_redir_cnt != '1))
        o_HC_redir_cnt <= o_HC_redir_cnt + CNT_W'(1);
    end
  end

  assign o_HC_pc_stall     = ctl.pc_stall;
  assign o_HC_pc_redirect  = ctl.pc_redirect;
  assign o_HC_if_id_stall  = ctl.if_id_stall;
  assign o_HC_if_id_flush  = ctl.if_id_flush;
  assign o_HC_id_ex_stall  = ctl.id_ex_stall;
  assign o_HC_id_ex_flush  = ctl.id_ex_flush;
  assign o_HC_ex_mem_stall = ctl.ex_mem_stall;
  assign o_HC_state        = state_q;

endmodule

// File: tb/tb_ysyx_22040386_hazard_ctrl.sv
// Scenario bench for the hazard sequencer: a default-width instance and a
// 4-bit-counter instance share stimulus; expected strobes/state per cycle go
// through a scoreboard queue, counters are tracked by a saturating model.
`timescale 1ns/1ps
module tb_ysyx_22040386_hazard_ctrl;

  // ctl bit order: {pc_stall, pc_redirect, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall}
  localparam logic [6:0] NONE   = 7'b0000000;
  localparam logic [6:0] STALL4 = 7'b1010101;
  localparam logic [6:0] JUMP   = 7'b0101010;
  localparam logic [6:0] LU     = 7'b1010010;
  localparam logic [6:0] IMEM   = 7'b1001000;
  localparam logic [6:0] DISC   = 7'b1001000;
  localparam logic [6:0] DISCD  = 7'b1001101;

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, mr, j, ib, db;
    logic [6:0] ctl;
    logic [1:0] st;
  } vec_t;
  typedef struct packed {
    logic [6:0] ctl;
    logic [1:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1, rs2, rd;
  logic u1, u2, mr, j, ib, db;
  logic [6:0] ctl_a, ctl_b;
  logic [1:0] st_a, st_b;
  logic [31:0] sc_a, rc_a;
  logic [3:0] sc_b, rc_b;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int ms = 0;
  int mrd = 0;

  always #5 clk = ~clk;

  ysyx_22040386_hazard_ctrl dut_a (
    .i_HC_clk(clk), .i_HC_rst_n(rst_n),
    .i_HC_id_rs1(rs1), .i_HC_id_rs2(rs2), .i_HC_id_use_rs1(u1), .i_HC_id_use_rs2(u2),
    .i_HC_ex_rd(rd), .i_HC_ex_mem_read(mr), .i_HC_ex_jump(j),
    .i_HC_imem_busy(ib), .i_HC_dmem_busy(db),
    .o_HC_pc_stall(ctl_a[6]), .o_HC_pc_redirect(ctl_a[5]), .o_HC_if_id_stall(ctl_a[4]),
    .o_HC_if_id_flush(ctl_a[3]), .o_HC_id_ex_stall(ctl_a[2]), .o_HC_id_ex_flush(ctl_a[1]),
    .o_HC_ex_mem_stall(ctl_a[0]), .o_HC_state(st_a),
    .o_HC_stall_cnt(sc_a), .o_HC_redir_cnt(rc_a)
  );

  ysyx_22040386_hazard_ctrl #(.RA_W(5), .CNT_W(4)) dut_b (
    .i_HC_clk(clk), .i_HC_rst_n(rst_n),
    .i_HC_id_rs1(rs1), .i_HC_id_rs2(rs2), .i_HC_id_use_rs1(u1), .i_HC_id_use_rs2(u2),
    .i_HC_ex_rd(rd), .i_HC_ex_mem_read(mr), .i_HC_ex_jump(j),
    .i_HC_imem_busy(ib), .i_HC_dmem_busy(db),
    .o_HC_pc_stall(ctl_b[6]), .o_HC_pc_redirect(ctl_b[5]), .o_HC_if_id_stall(ctl_b[4]),
    .o_HC_if_id_flush(ctl_b[3]), .o_HC_id_ex_stall(ctl_b[2]), .o_HC_id_ex_flush(ctl_b[1]),
    .o_HC_ex_mem_stall(ctl_b[0]), .o_HC_state(st_b),
    .o_HC_stall_cnt(sc_b), .o_HC_redir_cnt(rc_b)
  );

  function automatic vec_t v(input int a1, a2, ard, input int au1, au2, amr, aj, aib, adb,
                             input logic [6:0] ec, input int es);
    vec_t x;
    x.rs1 = 5'(a1); x.rs2 = 5'(a2); x.rd = 5'(ard);
    x.u1 = au1[0]; x.u2 = au2[0]; x.mr = amr[0]; x.j = aj[0]; x.ib = aib[0]; x.db = adb[0];
    x.ctl = ec; x.st = 2'(es);
    return x;
  endfunction

  function automatic logic [71:0] exp_cnt();
    return {32'(ms), 32'(mrd), (ms > 15) ? 4'hF : 4'(ms), (mrd > 15) ? 4'hF : 4'(mrd)};
  endfunction

  task automatic drive(input vec_t x);
    rs1 = x.rs1; rs2 = x.rs2; rd = x.rd;
    u1 = x.u1; u2 = x.u2; mr = x.mr; j = x.j; ib = x.ib; db = x.db;
    sb.push_back('{x.ctl, x.st});
  endtask

  task automatic idle_inputs();
    rs1 = '0; rs2 = '0; rd = '0; u1 = 0; u2 = 0; mr = 0; j = 0; ib = 0; db = 0;
  endtask

  task automatic test_reset();
    rs1 = 5; rs2 = 0; rd = 5; u1 = 1; u2 = 0; mr = 1; j = 1; ib = 1; db = 1;
    #12;
    checks++;
    if (ctl_a !== NONE || ctl_b !== NONE) begin
      errors++; $display("FAIL reset_ctl got %b/%b want %b", ctl_a, ctl_b, NONE);
    end
    checks++;
    if ({st_a, st_b, sc_a, rc_a, sc_b, rc_b} !== 76'd0) begin
      errors++; $display("FAIL reset_regs state %0d cnt %0d/%0d want all 0", st_a, sc_a, rc_a);
    end
    idle_inputs();
    @(posedge clk); #1; rst_n = 1'b1;
    ms = 0; mrd = 0;
  endtask

  task automatic test_load_use();
    vec_t t[$]; exp_t e;
    t.push_back(v(5, 0, 5, 1, 0, 1, 0, 0, 0, LU, 0));
    t.push_back(v(5, 0, 5, 1, 0, 0, 0, 0, 0, NONE, 0));   // ID/EX now holds the bubble
    t.push_back(v(0, 7, 7, 0, 1, 1, 0, 0, 0, LU, 0));
    t.push_back(v(0, 7, 7, 0, 1, 0, 0, 0, 0, NONE, 0));
    foreach (t[i]) begin
      @(posedge clk); #1; drive(t[i]); #3;
      e = sb.pop_front();
      checks++;
      if (ctl_a !== e.ctl || ctl_b !== e.ctl) begin errors++; $display("FAIL load_use[%0d] ctl got %b/%b want %b", i, ctl_a, ctl_b, e.ctl); end
      checks++;
      if (st_a !== e.st || st_b !== e.st) begin errors++; $display("FAIL load_use[%0d] state got %0d/%0d want %0d", i, st_a, st_b, e.st); end
      checks++;
      if ({sc_a, rc_a, sc_b, rc_b} !== exp_cnt()) begin errors++; $display("FAIL load_use[%0d] cnt got %h want %h", i, {sc_a, rc_a, sc_b, rc_b}, exp_cnt()); end
      if (e.ctl[6]) ms++;
      if (e.ctl[5]) mrd++;
    end
  endtask

  task automatic test_no_hazard();
    vec_t t[$]; exp_t e;
    t.push_back(v(0, 0, 0, 1, 0, 1, 0, 0, 0, NONE, 0));   // load to x0
    t.push_back(v(3, 9, 9, 1, 0, 1, 0, 0, 0, NONE, 0));   // rs2 match but rs2 unused
    t.push_back(v(5, 0, 5, 1, 0, 0, 0, 0, 0, NONE, 0));   // match but not a load
    foreach (t[i]) begin
      @(posedge clk); #1; drive(t[i]); #3;
      e = sb.pop_front();
      checks++;
      if (ctl_a !== e.ctl || ctl_b !== e.ctl) begin errors++; $display("FAIL no_hazard[%0d] ctl got %b/%b want %b", i, ctl_a, ctl_b, e.ctl); end
      checks++;
      if (st_a !== e.st || st_b !== e.st) begin errors++; $display("FAIL no_hazard[%0d] state got %0d/%0d want %0d", i, st_a, st_b, e.st); end
      checks++;
      if ({sc_a, rc_a, sc_b, rc_b} !== exp_cnt()) begin errors++; $display("FAIL no_hazard[%0d] cnt got %h want %h", i, {sc_a, rc_a, sc_b, rc_b}, exp_cnt()); end
      if (e.ctl[6]) ms++;
      if (e.ctl[5]) mrd++;
    end
  endtask

  task automatic test_imem();
    vec_t t[$]; exp_t e;
    t.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, IMEM, 0));
    t.push_back(v(5, 0, 5, 1, 0, 1, 0, 1, 0, LU, 0));     // load-use outranks fetch bubble
    t.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
    foreach (t[i]) begin
      @(posedge clk); #1; drive(t[i]); #3;
      e = sb.pop_front();
      checks++;
      if (ctl_a !== e.ctl || ctl_b !== e.ctl) begin errors++; $display("FAIL imem[%0d] ctl got %b/%b want %b", i, ctl_a, ctl_b, e.ctl); end
      checks++;
      if (st_a !== e.st || st_b !== e.st) begin errors++; $display("FAIL imem[%0d] state got %0d/%0d want %0d", i, st_a, st_b, e.st); end
      checks++;
      if ({sc_a, rc_a, sc_b, rc_b} !== exp_cnt()) begin errors++; $display("FAIL imem[%0d] cnt got %h want %h", i, {sc_a, rc_a, sc_b, rc_b}, exp_cnt()); end
      if (e.ctl[6]) ms++;
      if (e.ctl[5]) mrd++;
    end
  endtask

  task automatic test_jump_discard();
    vec_t t[$]; exp_t e;
    t.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, JUMP, 0));   // plain redirect, stays RUN
    t.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
    t.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, JUMP, 0));   // fetch outstanding -> DISCARD
    t.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, DISC, 2));   // jump ignored in DISCARD
    t.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, DISC, 2));
    t.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, DISC, 2));   // fetch done: flush once more
    t.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
    foreach (t[i]) begin
      @(posedge clk); #1; drive(t[i]); #3;
      e = sb.pop_front();
      checks++;
      if (ctl_a !== e.ctl || ctl_b !== e.ctl) begin errors++; $display("FAIL jump_discard[%0d] ctl got %b/%b want %b", i, ctl_a, ctl_b, e.ctl); end
      checks++;
      if (st_a !== e.st || st_b !== e.st) begin errors++; $display("FAIL jump_discard[%0d] state got %0d/%0d want %0d", i, st_a, st_b, e.st); end
      checks++;
      if ({sc_a, rc_a, sc_b, rc_b} !== exp_cnt()) begin errors++; $display("FAIL jump_discard[%0d] cnt got %h want %h", i, {sc_a, rc_a, sc_b, rc_b}, exp_cnt()); end
      if (e.ctl[6]) ms++;
      if (e.ctl[5]) mrd++;
    end
  endtask

  task automatic test_dmem_wait();
    vec_t t[$]; exp_t e;
    t.push_back(v(5, 0, 5, 1, 0, 1, 1, 0, 1, STALL4, 0));
    t.push_back(v(5, 0, 5, 1, 0, 1, 1, 0, 1, STALL4, 1));
    t.push_back(v(5, 0, 5, 1, 0, 1, 1, 0, 1, STALL4, 1));
    t.push_back(v(5, 0, 5, 1, 0, 1, 1, 0, 1, STALL4, 1));
    t.push_back(v(5, 0, 5, 1, 0, 1, 1, 0, 0, JUMP, 1));   // release: jump wins over lu
    t.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
    foreach (t[i]) begin
      @(posedge clk); #1; drive(t[i]); #3;
      e = sb.pop_front();
      checks++;
      if (ctl_a !== e.ctl || ctl_b !== e.ctl) begin errors++; $display("FAIL dmem_wait[%0d] ctl got %b/%b want %b", i, ctl_a, ctl_b, e.ctl); end
      checks++;
      if (st_a !== e.st || st_b !== e.st) begin errors++; $display("FAIL dmem_wait[%0d] state got %0d/%0d want %0d", i, st_a, st_b, e.st); end
      checks++;
      if ({sc_a, rc_a, sc_b, rc_b} !== exp_cnt()) begin errors++; $display("FAIL dmem_wait[%0d] cnt got %h want %h", i, {sc_a, rc_a, sc_b, rc_b}, exp_cnt()); end
      if (e.ctl[6]) ms++;
      if (e.ctl[5]) mrd++;
    end
  endtask

  task automatic test_discard_dmem();
    vec_t t[$]; exp_t e;
    t.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, JUMP, 0));
    t.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, DISCD, 2));
    t.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, DISCD, 2));
    t.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, STALL4, 0));
    t.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 1));
    t.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
    foreach (t[i]) begin
      @(posedge clk); #1; drive(t[i]); #3;
      e = sb.pop_front();
      checks++;
      if (ctl_a !== e.ctl || ctl_b !== e.ctl) begin errors++; $display("FAIL discard_dmem[%0d] ctl got %b/%b want %b", i, ctl_a, ctl_b, e.ctl); end
      checks++;
      if (st_a !== e.st || st_b !== e.st) begin errors++; $display("FAIL discard_dmem[%0d] state got %0d/%0d want %0d", i, st_a, st_b, e.st); end
      checks++;
      if ({sc_a, rc_a, sc_b, rc_b} !== exp_cnt()) begin errors++; $display("FAIL discard_dmem[%0d] cnt got %h want %h", i, {sc_a, rc_a, sc_b, rc_b}, exp_cnt()); end
      if (e.ctl[6]) ms++;
      if (e.ctl[5]) mrd++;
    end
  endtask

  task automatic test_back_to_back();
    vec_t t[$]; exp_t e;
    repeat (3) t.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, JUMP, 0));
    t.push_back(v(0, 6, 6, 0, 1, 1, 0, 0, 0, LU, 0));
    t.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
    foreach (t[i]) begin
      @(posedge clk); #1; drive(t[i]); #3;
      e = sb.pop_front();
      checks++;
      if (ctl_a !== e.ctl || ctl_b !== e.ctl) begin errors++; $display("FAIL back_to_back[%0d] ctl got %b/%b want %b", i, ctl_a, ctl_b, e.ctl); end
      checks++;
      if (st_a !== e.st || st_b !== e.st) begin errors++; $display("FAIL back_to_back[%0d] state got %0d/%0d want %0d", i, st_a, st_b, e.st); end
      checks++;
      if ({sc_a, rc_a, sc_b, rc_b} !== exp_cnt()) begin errors++; $display("FAIL back_to_back[%0d] cnt got %h want %h", i, {sc_a, rc_a, sc_b, rc_b}, exp_cnt()); end
      if (e.ctl[6]) ms++;
      if (e.ctl[5]) mrd++;
    end
  endtask

  task automatic test_reset_mid_wait();
    vec_t t[$]; exp_t e;
    t.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, STALL4, 0));
    t.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, STALL4, 1));
    foreach (t[i]) begin
      @(posedge clk); #1; drive(t[i]); #3;
      e = sb.pop_front();
      checks++;
      if (ctl_a !== e.ctl || ctl_b !== e.ctl) begin errors++; $display("FAIL reset_mid[%0d] ctl got %b/%b want %b", i, ctl_a, ctl_b, e.ctl); end
      checks++;
      if (st_a !== e.st || st_b !== e.st) begin errors++; $display("FAIL reset_mid[%0d] state got %0d/%0d want %0d", i, st_a, st_b, e.st); end
      if (e.ctl[6]) ms++;
      if (e.ctl[5]) mrd++;
    end
    // still in MEM_WAIT with dmem busy; pull reset between edges
    @(posedge clk); #2;
    checks++;
    if (ctl_a !== STALL4 || st_a !== 2'd1) begin errors++; $display("FAIL reset_mid_pre ctl %b state %0d want %b state 1", ctl_a, st_a, STALL4); end
    rst_n = 1'b0; #1;
    checks++;
    if (ctl_a !== NONE || ctl_b !== NONE) begin errors++; $display("FAIL reset_mid_ctl got %b/%b want %b", ctl_a, ctl_b, NONE); end
    checks++;
    if ({st_a, st_b, sc_a, rc_a, sc_b, rc_b} !== 76'd0) begin errors++; $display("FAIL reset_mid_regs state %0d cnt %0d/%0d want all 0", st_a, sc_a, rc_a); end
    @(posedge clk); #1;
    checks++;
    if (ctl_a !== NONE || st_a !== 2'd0 || sc_a !== 32'd0) begin errors++; $display("FAIL reset_hold ctl %b state %0d cnt %0d want 0", ctl_a, st_a, sc_a); end
    idle_inputs();
    rst_n = 1'b1;
    ms = 0; mrd = 0;
  endtask

  task automatic test_saturate();
    vec_t t[$]; exp_t e;
    repeat (20) t.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, IMEM, 0));
    repeat (17) t.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, JUMP, 0));
    t.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
    t.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
    foreach (t[i]) begin
      @(posedge clk); #1; drive(t[i]); #3;
      e = sb.pop_front();
      checks++;
      if (ctl_a !== e.ctl || ctl_b !== e.ctl) begin errors++; $display("FAIL saturate[%0d] ctl got %b/%b want %b", i, ctl_a, ctl_b, e.ctl); end
      checks++;
      if ({sc_a, rc_a, sc_b, rc_b} !== exp_cnt()) begin errors++; $display("FAIL saturate[%0d] cnt got %h want %h", i, {sc_a, rc_a, sc_b, rc_b}, exp_cnt()); end
      if (e.ctl[6]) ms++;
      if (e.ctl[5]) mrd++;
    end
    checks++;
    if (sc_b !== 4'hF || rc_b !== 4'hF || sc_a !== 32'(ms) || rc_a !== 32'(mrd)) begin
      errors++; $display("FAIL saturate_end cnt %0d/%0d %0d/%0d want %0d/%0d 15/15", sc_a, rc_a, sc_b, rc_b, ms, mrd);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_imem();
    test_jump_discard();
    test_dmem_wait();
    test_discard_dmem();
    test_back_to_back();
    test_reset_mid_wait();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
